// File: rtl/reg_display_scanner.sv
// -----------------------------------------------------------------------------
// reg_display_scanner
//
// Debug readout for the board display. Periodically (or when the selected
// register number changes) reads one register-file entry through the debug
// read port, converts its low 14 bits to four BCD digits with a sequential
// shift-add-3 engine, and multiplexes the digits onto a common 4-digit,
// active-low seven-segment display. Values above 9999 show as four dashes
// with ovf set. The block only reads register-file contents.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   UPDATE_DIV   clock cycles between periodic re-reads (>= 32)
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   sel_addr   in   5   register number to display
//   dbg_addr   out  5   register-file debug read address (held between reads)
//   dbg_data   in  32   debug read data, valid one cycle after dbg_addr
//   tho..one   out  4   BCD digits currently shown (4'hF = overflow dash)
//   seg        out  7   segments {g,f,e,d,c,b,a}, active low
//   an         out  4   digit enables, active low, an[3]=thousands
//   ovf        out  1   captured value exceeded 9999
//   busy       out  1   read/convert sequence in progress
// -----------------------------------------------------------------------------
module reg_display_scanner #(
   parameter int REFRESH_DIV = 50000,
   parameter int UPDATE_DIV  = 5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  sel_addr,
   output logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_data,
   output logic [3:0]  tho,
   output logic [3:0]  hun,
   output logic [3:0]  ten,
   output logic [3:0]  one,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        ovf,
   output logic        busy
);

   // --------------------------------------------------------------------------
   // Constants
   // --------------------------------------------------------------------------
   localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int UPD_W = $clog2(UPDATE_DIV);

   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);
   localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);
   localparam logic [UPD_W-1:0] UPD_ONE  = UPD_W'(1);

   localparam logic [31:0] MAX_DECIMAL = 32'd9999;
   localparam logic [3:0]  LAST_ITER   = 4'd13;   // 14 shifts: iterations 0..13
   localparam logic [3:0]  DASH_DIGIT  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_CONVERT,
      S_UPDATE
   } state_t;

   // --------------------------------------------------------------------------
   // Helper functions
   // --------------------------------------------------------------------------
   // Double-dabble correction: any BCD nibble >= 5 gets +3 so the following
   // left shift carries correctly into the next decimal digit.
   function automatic logic [15:0] f_bcd_adjust(input logic [15:0] i_bcd);
      logic [15:0] v;
      v = i_bcd;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            v[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end
      end
      return v;
   endfunction

   // Active-low {g,f,e,d,c,b,a}; F is the overflow dash, A-E blank.
   function automatic logic [6:0] f_seg_decode(input logic [3:0] i_digit);
      logic [6:0] s;
      case (i_digit)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'hF:    s = 7'b0111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // --------------------------------------------------------------------------
   // Registers and combinational signals
   // --------------------------------------------------------------------------
   state_t             r_state;
   state_t             w_next_state;

   logic [UPD_W-1:0]   r_upd_cnt;
   logic [REF_W-1:0]   r_ref_cnt;
   logic [1:0]         r_digit_sel;     // 0=ones, 1=ten, 2=hun, 3=tho
   logic [3:0]         r_an;
   logic [6:0]         r_seg;

   logic [4:0]         r_last_addr;
   logic               r_pending;
   logic [4:0]         r_dbg_addr;

   logic [13:0]        r_bin;
   logic [15:0]        r_bcd;
   logic [3:0]         r_iter;
   logic               r_ovf_next;

   logic [3:0]         r_tho;
   logic [3:0]         r_hun;
   logic [3:0]         r_ten;
   logic [3:0]         r_one;
   logic               r_ovf;

   logic               w_upd_tick;
   logic               w_ref_wrap;
   logic               w_addr_changed;
   logic               w_trigger;
   logic               w_start;
   logic               w_capture;
   logic               w_shift;
   logic               w_update;
   logic [15:0]        w_bcd_adj;
   logic [1:0]         w_sel_next;
   logic [3:0]         w_next_digit;

   assign w_upd_tick     = (r_upd_cnt == UPD_LAST);
   assign w_ref_wrap     = (r_ref_cnt == REF_LAST);
   assign w_addr_changed = (sel_addr != r_last_addr);
   assign w_trigger      = w_upd_tick || w_addr_changed || r_pending;
   assign w_bcd_adj      = f_bcd_adjust(r_bcd);

   // --------------------------------------------------------------------------
   // Sequence FSM: state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------------------
   // Sequence FSM: next state and datapath strobes
   // --------------------------------------------------------------------------
   // NOTE: every output of this block is defaulted first so no path through
   // the case leaves a signal unassigned (which would infer a latch).
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_capture    = 1'b0;
      w_shift      = 1'b0;
      w_update     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_start      = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         // One wait cycle covers the register-file read latency.
         S_FETCH: begin
            w_next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_capture    = 1'b1;
            w_next_state = S_CONVERT;
         end
         S_CONVERT: begin
            w_shift = 1'b1;
            if (r_iter == LAST_ITER) begin
               w_next_state = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_update     = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Trigger bookkeeping, read address and conversion datapath
   // --------------------------------------------------------------------------
   // NOTE: every register here is reset, including the conversion scratch
   // registers, so a reset mid-sequence cannot leak a partial result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_upd_cnt   <= '0;
         r_last_addr <= '0;
         r_pending   <= 1'b0;
         r_dbg_addr  <= '0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_iter      <= '0;
         r_ovf_next  <= 1'b0;
         r_tho       <= '0;
         r_hun       <= '0;
         r_ten       <= '0;
         r_one       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         // Free-running period counter; a tick that lands while busy is lost.
         r_upd_cnt <= w_upd_tick ? '0 : r_upd_cnt + UPD_ONE;

         // Address changes while busy collapse into a single pending request;
         // the address itself is re-sampled when the next sequence starts.
         if (w_start) begin
            r_pending   <= 1'b0;
            r_last_addr <= sel_addr;
            r_dbg_addr  <= sel_addr;
         end else if (r_state != S_IDLE && w_addr_changed) begin
            r_pending <= 1'b1;
         end

         // Overflow uses the full 32-bit value; only 14 bits are converted.
         if (w_capture) begin
            r_ovf_next <= (dbg_data > MAX_DECIMAL);
            r_bin      <= dbg_data[13:0];
            r_bcd      <= '0;
            r_iter     <= '0;
         end

         if (w_shift) begin
            r_bcd  <= {w_bcd_adj[14:0], r_bin[13]};
            r_bin  <= {r_bin[12:0], 1'b0};
            r_iter <= r_iter + 4'd1;
         end

         if (w_update) begin
            if (r_ovf_next) begin
               r_tho <= DASH_DIGIT;
               r_hun <= DASH_DIGIT;
               r_ten <= DASH_DIGIT;
               r_one <= DASH_DIGIT;
               r_ovf <= 1'b1;
            end else begin
               r_tho <= r_bcd[15:12];
               r_hun <= r_bcd[11:8];
               r_ten <= r_bcd[7:4];
               r_one <= r_bcd[3:0];
               r_ovf <= 1'b0;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Display multiplexer
   // --------------------------------------------------------------------------
   // Digit that becomes active on the next refresh wrap.
   always_comb begin
      w_sel_next = r_digit_sel + 2'd1;
      case (w_sel_next)
         2'd0:    w_next_digit = r_one;
         2'd1:    w_next_digit = r_ten;
         2'd2:    w_next_digit = r_hun;
         default: w_next_digit = r_tho;
      endcase
   end

   // an and seg are registered together on the wrap so the pattern only ever
   // changes at a digit boundary, even if the digits update mid-slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ref_cnt   <= '0;
         r_digit_sel <= 2'd0;
         r_an        <= 4'b1110;
         r_seg       <= 7'b1000000;
      end else begin
         if (w_ref_wrap) begin
            r_ref_cnt   <= '0;
            r_digit_sel <= w_sel_next;
            r_an        <= ~(4'b0001 << w_sel_next);
            r_seg       <= f_seg_decode(w_next_digit);
         end else begin
            r_ref_cnt <= r_ref_cnt + REF_ONE;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign dbg_addr = r_dbg_addr;
   assign tho      = r_tho;
   assign hun      = r_hun;
   assign ten      = r_ten;
   assign one      = r_one;
   assign ovf      = r_ovf;
   assign an       = r_an;
   assign seg      = r_seg;
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_reg_display_scanner
//
// Drives reg_display_scanner (REFRESH_DIV=4, UPDATE_DIV=64) against a
// register-file model with one cycle of read latency. A reference model
// built on edge numbers and decimal arithmetic predicts every output each
// cycle; directed sections add fixed-value checks for the key scenarios.
// -----------------------------------------------------------------------------
module tb_reg_display_scanner;

   localparam int R = 4;
   localparam int U = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  sel_addr = 5'd0;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [3:0]  tho, hun, ten, one;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        ovf;
   logic        busy;

   logic [31:0] regs [32];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Register file: synchronous debug read, data valid one cycle later.
   always @(posedge clk) dbg_data <= regs[dbg_addr];

   reg_display_scanner #(
      .REFRESH_DIV (R),
      .UPDATE_DIV  (U)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sel_addr (sel_addr),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .tho      (tho),
      .hun      (hun),
      .ten      (ten),
      .one      (one),
      .seg      (seg),
      .an       (an),
      .ovf      (ovf),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [6:0] exp_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         4'hF: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model. m_n is the number of rising edges since reset release.
   // A sequence triggered at edge k reads the register at edge k+1 and
   // publishes its digits at edge k+17; the display advances at every
   // multiple of R, the periodic tick fires at every multiple of U.
   // ---------------------------------------------------------------------------
   int          m_n, m_k;
   bit          m_active, m_pending, m_ovf;
   logic [4:0]  m_last, m_addr;
   logic [31:0] m_val;
   logic [3:0]  m_dig [4];     // index 0 = ones
   logic [3:0]  m_an;
   logic [6:0]  m_seg;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_n = 0; m_k = 0; m_active = 0; m_pending = 0; m_ovf = 0;
         m_last = 0; m_addr = 0; m_val = 0;
         for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
         m_an = 4'b1110; m_seg = 7'b1000000;
      end else begin
         m_n++;
         if (m_n % R == 0) begin
            m_an  = ~(4'b0001 << ((m_n / R) % 4));
            m_seg = exp_seg(m_dig[(m_n / R) % 4]);
         end
         if (m_active) begin
            if (sel_addr != m_last) m_pending = 1;
            if (m_n == m_k + 1) m_val = regs[m_addr];
            if (m_n == m_k + 17) begin
               m_active = 0;
               if (m_val > 32'd9999) begin
                  for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
                  m_ovf = 1;
               end else begin
                  m_dig[3] = 4'(m_val / 1000);
                  m_dig[2] = 4'((m_val / 100) % 10);
                  m_dig[1] = 4'((m_val / 10) % 10);
                  m_dig[0] = 4'(m_val % 10);
                  m_ovf = 0;
               end
            end
         end else if ((m_n % U == 0) || (sel_addr != m_last) || m_pending) begin
            m_active = 1; m_k = m_n; m_last = sel_addr; m_addr = sel_addr; m_pending = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         check("dbg_addr", 32'(dbg_addr), 32'(m_addr));
         check("busy", 32'(busy), 32'(m_active));
         check("digits", 32'({tho, hun, ten, one}), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
         check("ovf", 32'(ovf), 32'(m_ovf));
         check("an", 32'(an), 32'(m_an));
         check("seg", 32'(seg), 32'(m_seg));
      end
   end

   // ---------------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------------
   task automatic wait_idle();
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1;
      end
      if (!seen) check("wait_idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dbg_addr"}, 32'(dbg_addr), 32'd0);
      check({tag, "_digits"}, 32'({tho, hun, ten, one}), 32'h0000);
      check({tag, "_ovf"}, 32'(ovf), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_an"}, 32'(an), 32'b1110);
      check({tag, "_seg"}, 32'(seg), 32'b1000000);
   endtask

   task automatic run_value(input logic [4:0] addr, input logic [31:0] value,
                            input logic [15:0] exp_digits, input logic exp_ovf);
      wait_idle();
      regs[addr] = value;
      sel_addr   = addr;
      repeat (18) @(negedge clk);
      check("value_digits", 32'({tho, hun, ten, one}), 32'(exp_digits));
      check("value_ovf", 32'(ovf), 32'(exp_ovf));
      check("value_busy_low", 32'(busy), 32'd0);
   endtask

   function automatic logic [6:0] seg_for_1234(input logic [3:0] a);
      case (a)
         4'b1110: return 7'b0011001;
         4'b1101: return 7'b0110000;
         4'b1011: return 7'b0100100;
         4'b0111: return 7'b1111001;
         default: return 7'bxxxxxxx;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bit found;
      int lat;

      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 1111 + 7);
      regs[0] = 0;
      regs[5] = 1234;
      regs[3] = 303;
      regs[7] = 777;
      regs[9] = 909;

      // Reset
      reset = 1'b0;
      sel_addr = 5'd0;
      repeat (3) @(negedge clk);
      check_reset_values("in_reset");
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("after_release");

      // Basic conversion of 1234 from register 5
      sel_addr = 5'd5;
      @(negedge clk);
      check("basic_busy_rise", 32'(busy), 32'd1);
      check("basic_dbg_addr", 32'(dbg_addr), 32'd5);
      repeat (17) @(negedge clk);
      check("basic_digits", 32'({tho, hun, ten, one}), 32'h1234);
      check("basic_ovf", 32'(ovf), 32'd0);
      check("basic_busy_fall", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check("basic_seg", 32'(seg), 32'(seg_for_1234(an)));
         @(negedge clk);
      end

      // Boundary values
      run_value(5'd10, 32'd9999, 16'h9999, 1'b0);
      run_value(5'd11, 32'd10000, 16'hFFFF, 1'b1);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check("dash_seg", 32'(seg), 32'b0111111);
         @(negedge clk);
      end
      run_value(5'd12, 32'h0001_0005, 16'hFFFF, 1'b1);
      run_value(5'd13, 32'd0, 16'h0000, 1'b0);

      // Address changes while busy: 3 -> 7 -> 9
      wait_idle();
      sel_addr = 5'd3;
      repeat (6) @(negedge clk);
      sel_addr = 5'd7;
      repeat (3) @(negedge clk);
      sel_addr = 5'd9;
      repeat (9) @(negedge clk);
      check("chg_first_digits", 32'({tho, hun, ten, one}), 32'h0303);
      check("chg_busy_fall", 32'(busy), 32'd0);
      @(negedge clk);
      check("chg_restart_busy", 32'(busy), 32'd1);
      check("chg_restart_addr", 32'(dbg_addr), 32'd9);
      repeat (17) @(negedge clk);
      check("chg_second_digits", 32'({tho, hun, ten, one}), 32'h0909);
      check("chg_second_done", 32'(busy), 32'd0);

      // Periodic refresh picks up new register contents
      wait_idle();
      regs[20] = 42;
      sel_addr = 5'd20;
      repeat (18) @(negedge clk);
      check("periodic_before", 32'({tho, hun, ten, one}), 32'h0042);
      regs[20] = 815;
      @(negedge clk);
      check("periodic_not_yet", 32'({tho, hun, ten, one}), 32'h0042);
      found = 0;
      lat = 0;
      for (int i = 0; i < U + 24 && !found; i++) begin
         @(negedge clk);
         lat++;
         if ({tho, hun, ten, one} == 16'h0815) found = 1;
      end
      check("periodic_seen", 32'(found), 32'd1);
      check("periodic_latency_ok", 32'(lat <= U + 18), 32'd1);

      // Randomized traffic on addresses 0..7
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 4) begin
            sel_addr = 5'($urandom_range(0, 7));
         end else if (r < 10) begin
            case ($urandom_range(0, 3))
               0:       regs[$urandom_range(0, 7)] = 32'($urandom_range(0, 9999));
               1:       regs[$urandom_range(0, 7)] = 32'($urandom_range(9990, 10010));
               2:       regs[$urandom_range(0, 7)] = $urandom;
               default: regs[$urandom_range(0, 7)] = 32'($urandom_range(0, 99));
            endcase
         end
         @(negedge clk);
      end

      // Reset during CONVERT cycle 6
      regs[0] = 0;
      wait_idle();
      regs[21] = 4321;
      sel_addr = 5'd21;
      repeat (9) @(negedge clk);
      check("midrst_busy_before", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_reset_values("mid_reset");
      sel_addr = 5'd0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (20) @(negedge clk);
      check("post_reset_digits", 32'({tho, hun, ten, one}), 32'h0000);
      check("post_reset_busy", 32'(busy), 32'd0);
      repeat (100) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_display_scanner.md
# reg_display_scanner

Debug readout block for the single-cycle core's board display. It periodically reads one register-file entry through a dedicated debug read port, converts the low 14 bits to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a common 4-digit seven-segment display. It is a pure consumer of register-file contents and never writes architectural state.

## Interface

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit during multiplexing (minimum 2).
- UPDATE_DIV, 5000000: clock cycles between periodic re-reads of the selected register (minimum 32).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sel_addr  in  5  register number to display.
- dbg_addr  out  5  register-file debug read address.
- dbg_data  in  32  register-file debug read data; must be valid one cycle after dbg_addr changes.
- tho, hun, ten, one  out  4 each  BCD digits currently displayed.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[3]=thousands, an[0]=ones.
- ovf  out  1  high when the captured value exceeds 9999.
- busy  out  1  high while a read/convert sequence is in progress.

## Operation

- Reset values: dbg_addr=0, tho=hun=ten=one=0, ovf=0, busy=0, an=4'b1110, seg=7'b1000000, FSM in IDLE, both counters 0, pending=0, last_addr=0.
- Trigger: in IDLE, a sequence starts when (a) the update counter reaches UPDATE_DIV-1, or (b) sel_addr differs from last_addr, or (c) pending=1. The update counter wraps to 0 and keeps counting at all times.
- FSM states and transitions:
  - IDLE: on trigger, latch last_addr=sel_addr, drive dbg_addr=sel_addr, clear pending, set busy -> FETCH.
  - FETCH: one wait cycle for register-file read -> CAPTURE.
  - CAPTURE: latch value=dbg_data[31:0]; ovf_next = (dbg_data > 9999), unsigned, full 32-bit compare; load shift register with dbg_data[13:0] and BCD accumulator 0 -> CONVERT, iteration count 0.
  - CONVERT: exactly 14 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift {bcd,bin} left by 1. After the 14th shift -> UPDATE.
  - UPDATE: if ovf_next, load tho=hun=ten=one=4'hF and ovf=1; otherwise load BCD nibbles and ovf=0. Clear busy -> IDLE.
- sel_addr change while busy: set pending; the current sequence completes with the old address, then a new one starts from IDLE on the following cycle. Multiple changes collapse into one pending request; the address used is sel_addr sampled on leaving IDLE.
- Periodic tick while busy: ignored (not queued).
- Display mux: refresh counter counts 0..REFRESH_DIV-1; on wrap, the active digit advances ones -> ten -> hun -> tho -> ones. an is one-cold for the active digit; seg is the decode of that digit.
- Segment decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, F (overflow) = 0111111 (dash). Nibbles A-E never occur; decode them to 1111111 (blank).
- Asserting reset mid-sequence aborts immediately to reset values. No partial update of the digits occurs.

## Timing

- Trigger sampled at edge k (IDLE -> FETCH): dbg_addr valid after edge k; data captured at edge k+2; CONVERT occupies edges k+3..k+16; digits/ovf update and busy falls at edge k+17. The sequence is 17 cycles from trigger edge to new digits.
- busy is high from after edge k through edge k+16 inclusive.
- The earliest retrigger from pending is edge k+18.
- After reset release, the first periodic sequence starts at edge UPDATE_DIV; a sel_addr != 0 present at release triggers at the first edge.
- an/seg change only on refresh wrap, every REFRESH_DIV cycles; the full display cycle is 4*REFRESH_DIV.
- dbg_addr holds its last value between sequences.

## Test plan

- Reset: hold reset low, then release with sel_addr=0 -> all reset values above, an=1110, seg=1000000, busy=0.
- Basic conversion (REFRESH_DIV=4, UPDATE_DIV=64): reg 5 = 1234, sel_addr 0->5 -> 17 cycles later tho..one = 1,2,3,4, ovf=0, and an cycles 1110,1101,1011,0111 every 4 cycles with seg = 0011001,0110000,0100100,1111001.
- Boundary values: 9999 -> 9,9,9,9, ovf=0; 10000 -> all digits F, seg=0111111 on every digit, ovf=1; 0x0001_0005 (low 14 bits small but value > 9999) -> ovf=1; 0 -> 0,0,0,0.
- Change while busy: switch sel_addr 3->7->9 during CONVERT -> current result for reg 3 lands, a single new sequence reads reg 9 starting one cycle after busy falls, and reg 7 is never displayed.
- Periodic refresh: with sel_addr fixed, change reg contents from 42 to 815 -> display shows 0815 after the next UPDATE_DIV tick plus 17 cycles.
- Reset mid-CONVERT: assert reset at CONVERT cycle 6 -> outputs return to reset values at once; after release, no stale digits appear.
